snake_core: RTL and testbench

Parametrised snake game engine: owns the snake body, its movement, growth and collision rules, and publishes the occupancy bitmap for the LED-matrix path. It generalises the fixed 8x8 game to any grid size and maximum length, and adds a selectable wrap or wall boundary mode, 180° turn rejection and a win condition. It sits between the keyboard direction decoder and apple generator on the input side, and the display and score logic on the output side.

---
 rtl/snake_pkg.sv | 81 ++++++++
 rtl/snake_body_ram.sv | 32 +++
 rtl/snake_core.sv | 217 +++++++++++++++++++++
 tb/tb_snake_core.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared types and the single-step movement rule of the snake.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        RUN    = 3'd1,
        EVAL   = 3'd2,
        COMMIT = 3'd3,
        OVER   = 3'd4,
        WON    = 3'd5
    } state_t;

    typedef struct packed {
        int   x;
        int   y;
        logic wall;
    } step_t;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Explicit edge compares rather than modulo so non-power-of-2 grids wrap correctly.
    function automatic step_t next_cell(input int x, input int y, input dir_t dir,
                                        input logic wrap, input int grid_w, input int grid_h);
        step_t s;
        s.x    = x;
        s.y    = y;
        s.wall = 1'b0;
        case (dir)
            UP: begin
                if (y == grid_h - 1) begin
                    if (wrap) s.y = 0;
                    else      s.wall = 1'b1;
                end else begin
                    s.y = y + 1;
                end
            end
            RIGHT: begin
                if (x == grid_w - 1) begin
                    if (wrap) s.x = 0;
                    else      s.wall = 1'b1;
                end else begin
                    s.x = x + 1;
                end
            end
            DOWN: begin
                if (y == 0) begin
                    if (wrap) s.y = grid_h - 1;
                    else      s.wall = 1'b1;
                end else begin
                    s.y = y - 1;
                end
            end
            LEFT: begin
                if (x == 0) begin
                    if (wrap) s.x = grid_w - 1;
                    else      s.wall = 1'b1;
                end else begin
                    s.x = x - 1;
                end
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_body_ram.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_ram
// Description : Coordinate ring for the snake body; sync write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_body_ram #(
    parameter int DEPTH = 64,
    parameter int X_W   = 3,
    parameter int Y_W   = 3,
    parameter int A_W   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [A_W-1:0] waddr,
    input  logic [X_W-1:0] wx,
    input  logic [Y_W-1:0] wy,
    input  logic [A_W-1:0] raddr,
    output logic [X_W-1:0] rx,
    output logic [Y_W-1:0] ry
);

    logic [X_W+Y_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= {wx, wy};
    end

    assign {rx, ry} = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/snake_core.sv
`default_nettype none
// ============================================================================
// Module      : snake_core
// Description : Snake engine: body ring, movement, growth, collisions, bitmap.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_core
    import snake_pkg::*;
#(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int MAX_LEN = 64,
    parameter int WRAP    = 1,
    localparam int X_W    = $clog2(GRID_W),
    localparam int Y_W    = $clog2(GRID_H),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     pause,
    input  logic [1:0]               dir_in,
    input  logic                     apple_valid,
    input  logic [X_W-1:0]           apple_x,
    input  logic [Y_W-1:0]           apple_y,
    output logic [GRID_W*GRID_H-1:0] frame,
    output logic [X_W-1:0]           head_x,
    output logic [Y_W-1:0]           head_y,
    output logic [LEN_W-1:0]         len,
    output logic                     eaten,
    output logic                     busy,
    output logic                     game_over,
    output logic                     won
);

    localparam int c_n  = GRID_W * GRID_H;
    localparam int c_iw = $clog2(c_n);
    localparam int c_cw = $clog2(c_n + 1);
    localparam int c_pw = $clog2(MAX_LEN);

    state_t            r_state, w_state_nxt;
    logic [c_n-1:0]    r_frame;
    logic [c_cw-1:0]   r_clr_cnt;
    logic [X_W-1:0]    r_head_x, r_nx, w_nx, w_tx, w_wx;
    logic [Y_W-1:0]    r_head_y, r_ny, w_ny, w_ty, w_wy;
    logic [LEN_W-1:0]  r_len;
    logic              r_eaten, r_over, r_won;
    dir_t              r_dir;
    logic [c_pw-1:0]   r_hp, r_tp, w_waddr;
    logic [c_iw-1:0]   r_nidx, w_nidx, w_tidx;
    logic              r_wall, r_self, r_grow;
    logic              w_grow, w_self, w_we;
    step_t             w_step;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [c_iw-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return c_iw'(int'(x) * GRID_H + int'(y));
    endfunction

    snake_body_ram #(
        .DEPTH (MAX_LEN),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .A_W   (c_pw)
    ) u_body (
        .clk   (CLK),
        .we    (w_we),
        .waddr (w_waddr),
        .wx    (w_wx),
        .wy    (w_wy),
        .raddr (r_tp),
        .rx    (w_tx),
        .ry    (w_ty)
    );

    // Candidate head and collision flags, registered in EVAL and acted on in COMMIT.
    always_comb begin
        w_step = next_cell(int'(r_head_x), int'(r_head_y), r_dir, WRAP != 0, GRID_W, GRID_H);
        w_nx   = X_W'(w_step.x);
        w_ny   = Y_W'(w_step.y);
        w_nidx = cell_idx(w_nx, w_ny);
        w_tidx = cell_idx(w_tx, w_ty);
        w_grow = apple_valid && (apple_x == w_nx) && (apple_y == w_ny);
        w_self = r_frame[w_nidx] && !((w_nidx == w_tidx) && !w_grow);
    end

    always_ff @(posedge CLK) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = ptr_inc(r_hp);
        w_wx        = r_nx;
        w_wy        = r_ny;
        case (r_state)
            INIT: begin
                // Tail goes in slot 0 while clearing starts; head in slot 1 on exit.
                if (r_clr_cnt == '0) begin
                    w_we    = 1'b1;
                    w_waddr = '0;
                    w_wx    = X_W'(1);
                    w_wy    = '0;
                end
                if (r_clr_cnt == c_cw'(c_n)) begin
                    w_we        = 1'b1;
                    w_waddr     = c_pw'(1);
                    w_wx        = X_W'(1);
                    w_wy        = Y_W'(1);
                    w_state_nxt = RUN;
                end
            end
            RUN:    if (tick && !pause) w_state_nxt = EVAL;
            EVAL:   w_state_nxt = COMMIT;
            COMMIT: begin
                if (r_wall || r_self) begin
                    w_state_nxt = OVER;
                end else begin
                    w_we = 1'b1;
                    if (r_grow && (r_len == LEN_W'(MAX_LEN - 1))) w_state_nxt = WON;
                    else                                          w_state_nxt = RUN;
                end
            end
            OVER:    ;
            WON:     ;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_frame   <= '0;
            r_clr_cnt <= '0;
            r_head_x  <= X_W'(1);
            r_head_y  <= Y_W'(1);
            r_len     <= '0;
            r_eaten   <= 1'b0;
            r_over    <= 1'b0;
            r_won     <= 1'b0;
            r_dir     <= UP;
            r_hp      <= '0;
            r_tp      <= '0;
            r_nx      <= '0;
            r_ny      <= '0;
            r_nidx    <= '0;
            r_wall    <= 1'b0;
            r_self    <= 1'b0;
            r_grow    <= 1'b0;
        end else begin
            r_eaten <= 1'b0;
            case (r_state)
                INIT: begin
                    if (r_clr_cnt != c_cw'(c_n)) begin
                        r_frame[r_clr_cnt[c_iw-1:0]] <= 1'b0;
                        r_clr_cnt                    <= r_clr_cnt + 1'b1;
                    end else begin
                        r_frame[cell_idx(X_W'(1), Y_W'(0))] <= 1'b1;
                        r_frame[cell_idx(X_W'(1), Y_W'(1))] <= 1'b1;
                        r_head_x <= X_W'(1);
                        r_head_y <= Y_W'(1);
                        r_len    <= LEN_W'(2);
                        r_dir    <= UP;
                        r_hp     <= c_pw'(1);
                        r_tp     <= '0;
                    end
                end
                RUN: begin
                    if (tick && !pause && (dir_in != opposite(r_dir))) r_dir <= dir_t'(dir_in);
                end
                EVAL: begin
                    r_nx   <= w_nx;
                    r_ny   <= w_ny;
                    r_nidx <= w_nidx;
                    r_wall <= w_step.wall;
                    r_self <= w_self;
                    r_grow <= w_grow;
                end
                COMMIT: begin
                    if (r_wall || r_self) begin
                        r_over <= 1'b1;
                    end else begin
                        // Tail clear precedes head set so a head entering the vacated cell keeps it lit.
                        if (!r_grow) begin
                            r_frame[w_tidx] <= 1'b0;
                            r_tp            <= ptr_inc(r_tp);
                        end else begin
                            r_len   <= r_len + 1'b1;
                            r_eaten <= 1'b1;
                            if (r_len == LEN_W'(MAX_LEN - 1)) r_won <= 1'b1;
                        end
                        r_frame[r_nidx] <= 1'b1;
                        r_hp            <= ptr_inc(r_hp);
                        r_head_x        <= r_nx;
                        r_head_y        <= r_ny;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame     = r_frame;
    assign head_x    = r_head_x;
    assign head_y    = r_head_y;
    assign len       = r_len;
    assign eaten     = r_eaten;
    assign busy      = (r_state == INIT) || (r_state == EVAL) || (r_state == COMMIT);
    assign game_over = r_over;
    assign won       = r_won;

endmodule
`default_nettype wire

// File: tb/tb_snake_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_core
// Description : Self-checking bench for snake_core against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_core;

    localparam int c_ni = 3;

    logic            clk = 1'b0;
    logic [c_ni-1:0] rst = '0;
    logic [c_ni-1:0] tk  = '0;
    logic            pause = 1'b0;
    logic [1:0]      dir   = 2'd0;
    logic            av    = 1'b0;
    logic [2:0]      ax    = 3'd0;
    logic [2:0]      ay    = 3'd0;

    logic [63:0] frame0, frame1;
    logic [8:0]  frame2;
    logic [2:0]  hx0, hy0, hx1, hy1;
    logic [1:0]  hx2, hy2;
    logic [6:0]  len0, len1;
    logic [1:0]  len2;
    logic [c_ni-1:0] eat, bsy, ovr, wn;

    logic [63:0] fr [c_ni];
    logic [2:0]  hx [c_ni];
    logic [2:0]  hy [c_ni];
    logic [6:0]  ln [c_ni];

    assign fr[0] = frame0;
    assign fr[1] = frame1;
    assign fr[2] = {55'd0, frame2};
    assign hx[0] = hx0;
    assign hx[1] = hx1;
    assign hx[2] = {1'b0, hx2};
    assign hy[0] = hy0;
    assign hy[1] = hy1;
    assign hy[2] = {1'b0, hy2};
    assign ln[0] = len0;
    assign ln[1] = len1;
    assign ln[2] = {5'd0, len2};

    always #5 clk = ~clk;

    snake_core #(.GRID_W(8), .GRID_H(8), .MAX_LEN(64), .WRAP(1)) u_dut_wrap (
        .CLK(clk), .reset(rst[0]), .tick(tk[0]), .pause(pause), .dir_in(dir),
        .apple_valid(av), .apple_x(ax), .apple_y(ay), .frame(frame0),
        .head_x(hx0), .head_y(hy0), .len(len0), .eaten(eat[0]), .busy(bsy[0]),
        .game_over(ovr[0]), .won(wn[0]));

    snake_core #(.GRID_W(8), .GRID_H(8), .MAX_LEN(64), .WRAP(0)) u_dut_wall (
        .CLK(clk), .reset(rst[1]), .tick(tk[1]), .pause(pause), .dir_in(dir),
        .apple_valid(av), .apple_x(ax), .apple_y(ay), .frame(frame1),
        .head_x(hx1), .head_y(hy1), .len(len1), .eaten(eat[1]), .busy(bsy[1]),
        .game_over(ovr[1]), .won(wn[1]));

    snake_core #(.GRID_W(3), .GRID_H(3), .MAX_LEN(3), .WRAP(1)) u_dut_small (
        .CLK(clk), .reset(rst[2]), .tick(tk[2]), .pause(pause), .dir_in(dir),
        .apple_valid(av), .apple_x(ax[1:0]), .apple_y(ay[1:0]), .frame(frame2),
        .head_x(hx2), .head_y(hy2), .len(len2), .eaten(eat[2]), .busy(bsy[2]),
        .game_over(ovr[2]), .won(wn[2]));

    int checks   = 0;
    int failures = 0;

    // Reference model: body as a queue of cells (x*256+y), tail at front.
    int cur, gw, gh, ml;
    bit wrap;
    int bq[$];
    int mdir;
    int mst;            // 0 playing, 1 game over, 2 won
    int DX[4] = '{0, 1, 0, -1};
    int DY[4] = '{1, 0, -1, 0};

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (inst %0d, t=%0t)", tag, got, exp, cur, $time);
        end
    endtask

    function automatic logic [63:0] m_frame();
        logic [63:0] f = '0;
        foreach (bq[i]) f[(bq[i] / 256) * gh + (bq[i] % 256)] = 1'b1;
        return f;
    endfunction

    task automatic use_inst(input int i);
        cur  = i;
        gw   = (i == 2) ? 3 : 8;
        gh   = gw;
        ml   = (i == 2) ? 3 : 64;
        wrap = (i != 1);
    endtask

    task automatic compare_all(input string tag);
        check_value({tag, "_frame"}, fr[cur], m_frame());
        check_value({tag, "_hx"},    64'(hx[cur]), 64'(bq[$] / 256));
        check_value({tag, "_hy"},    64'(hy[cur]), 64'(bq[$] % 256));
        check_value({tag, "_len"},   64'(ln[cur]), 64'(bq.size()));
        check_value({tag, "_over"},  64'(ovr[cur]), 64'(mst == 1));
        check_value({tag, "_won"},   64'(wn[cur]), 64'(mst == 2));
        check_value({tag, "_busy"},  64'(bsy[cur]), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst[cur] = 1'b1;
        tk       = '0;
        pause    = 1'b0;
        @(negedge clk);
        check_value("rst_frame", fr[cur], 64'd0);
        check_value("rst_len",   64'(ln[cur]), 64'd0);
        check_value("rst_eaten", 64'(eat[cur]), 64'd0);
        check_value("rst_over",  64'(ovr[cur]), 64'd0);
        check_value("rst_won",   64'(wn[cur]), 64'd0);
        check_value("rst_busy",  64'(bsy[cur]), 64'd1);
        check_value("rst_head",  64'({hx[cur], hy[cur]}), 64'({3'd1, 3'd1}));
        rst[cur] = 1'b0;
        for (int k = 0; k < gw * gh; k++) begin
            tk[cur] = (k == 3);
            @(negedge clk);
        end
        tk[cur] = 1'b0;
        check_value("init_pre_frame", fr[cur], 64'd0);
        check_value("init_pre_busy",  64'(bsy[cur]), 64'd1);
        @(negedge clk);
        bq.delete();
        bq.push_back(1 * 256 + 0);
        bq.push_back(1 * 256 + 1);
        mdir = 0;
        mst  = 0;
        compare_all("init");
    endtask

    task automatic model_step(input int d, input bit a_v, input int a_x, input int a_y, output bit ate);
        int hx_, hy_, nx, ny, nc;
        bit wall, grow, hit;
        ate = 1'b0;
        if (d != (mdir ^ 2)) mdir = d;
        hx_  = bq[$] / 256;
        hy_  = bq[$] % 256;
        nx   = hx_ + DX[mdir];
        ny   = hy_ + DY[mdir];
        wall = (nx < 0) || (nx >= gw) || (ny < 0) || (ny >= gh);
        if (wrap) begin
            nx   = (nx + gw) % gw;
            ny   = (ny + gh) % gh;
            wall = 1'b0;
        end
        nc   = nx * 256 + ny;
        grow = a_v && (nx == a_x) && (ny == a_y);
        hit  = 1'b0;
        foreach (bq[i]) if (bq[i] == nc && !(i == 0 && !grow)) hit = 1'b1;
        if (wall || hit) begin
            mst = 1;
        end else begin
            bq.push_back(nc);
            if (!grow) void'(bq.pop_front());
            else begin
                ate = 1'b1;
                if (bq.size() == ml) mst = 2;
            end
        end
    endtask

    task automatic step(input int d, input bit a_v, input int a_x, input int a_y,
                        input bit pz, input bit probe);
        bit acc, ate;
        @(negedge clk);
        dir     = 2'(d);
        av      = a_v;
        ax      = 3'(a_x);
        ay      = 3'(a_y);
        pause   = pz;
        tk[cur] = 1'b1;
        @(negedge clk);
        tk[cur] = probe;
        acc = (mst == 0) && !pz;
        ate = 1'b0;
        if (acc) model_step(d, a_v, a_x, a_y, ate);
        check_value("busy_eval", 64'(bsy[cur]), 64'(acc));
        @(negedge clk);
        tk[cur] = 1'b0;
        pause   = 1'b0;
        check_value("eaten_early", 64'(eat[cur]), 64'd0);
        @(negedge clk);
        check_value("eaten", 64'(eat[cur]), 64'(ate));
        compare_all("step");
        @(negedge clk);
        check_value("eaten_width", 64'(eat[cur]), 64'd0);
        av = 1'b0;
    endtask

    initial begin
        int d, eff, nx, ny, a_x, a_y;
        bit a_v;

        // Straight-up moves on 8x8 wrap.
        use_inst(0);
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check_value("up3_bits", 64'(fr[0][12:11]), 64'd3);
        check_value("up3_clear", 64'(fr[0][10:8]), 64'd0);
        check_value("up3_head", 64'({hx[0], hy[0]}), 64'({3'd1, 3'd4}));

        // Wrap vs wall on the right edge.
        for (int i = 0; i < 2; i++) begin
            use_inst(i);
            do_reset();
            step(0, 0, 0, 0, 0, 0);
            repeat (8) step(1, 0, 0, 0, 0, 0);
        end
        use_inst(0);
        check_value("wrap_head", 64'({hx[0], hy[0], ovr[0]}), 64'({3'd1, 3'd2, 1'b0}));
        check_value("wall_over", 64'(ovr[1]), 64'd1);

        // Eat, reverse rejection, pause.
        do_reset();
        step(0, 1, 1, 2, 0, 0);
        check_value("eat_len", 64'(ln[0]), 64'd3);
        check_value("eat_tail_kept", 64'(fr[0][8]), 64'd1);
        step(2, 0, 0, 0, 0, 1);
        check_value("reverse_head", 64'({hx[0], hy[0]}), 64'({3'd1, 3'd3}));
        step(1, 0, 0, 0, 1, 1);

        // Square loop: entering the vacated tail is legal unless eating there.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            step(0, 1, 1, 2, 0, 0);
            step(1, 1, 2, 2, 0, 0);
            step(2, 0, 0, 0, 0, 0);
            step(3, pass == 1, 1, 1, 0, 0);
            check_value("tail_chase_over", 64'(ovr[0]), 64'(pass == 1));
            step(0, 0, 0, 0, 0, 0);
        end

        // Small grid: win, ignored ticks, reset during EVAL.
        use_inst(2);
        do_reset();
        step(0, 1, 1, 2, 0, 0);
        check_value("small_won", 64'(wn[2]), 64'd1);
        step(1, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        dir = 2'd0; av = 1'b1; ax = 3'd1; ay = 3'd2; tk[2] = 1'b1;
        @(negedge clk);
        tk[2]  = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check_value("abort_busy", 64'(bsy[2]), 64'd1);
        check_value("abort_len", 64'(ln[2]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check_value("abort_eaten", 64'(eat[2]), 64'd0);
            @(negedge clk);
        end
        av = 1'b0;

        // Randomized play on both 8x8 variants.
        for (int i = 0; i < 2; i++) begin
            use_inst(i);
            do_reset();
            for (int k = 0; k < 120; k++) begin
                if (mst != 0) do_reset();
                d   = int'($urandom_range(3));
                eff = (d == (mdir ^ 2)) ? mdir : d;
                nx  = (bq[$] / 256 + DX[eff] + gw) % gw;
                ny  = (bq[$] % 256 + DY[eff] + gh) % gh;
                if ($urandom_range(2) == 0) begin
                    a_v = 1'b1; a_x = nx; a_y = ny;
                end else begin
                    a_v = 1'($urandom_range(1));
                    a_x = int'($urandom_range(gw - 1));
                    a_y = int'($urandom_range(gh - 1));
                end
                step(d, a_v, a_x, a_y, $urandom_range(5) == 0, 1'($urandom_range(1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
